// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage between the fetch queue and execute.
// Hides the register file's read latency and same-edge write hazard.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rsel1,
    output logic [4:0]      rf_rsel2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_wsel,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] hold1;
    logic [XLEN-1:0] hold2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
    logic            fwd1;
    logic            fwd2;

    logic            accept;
    logic            fire;
    logic            hold_en;
    logic            snoop1;
    logic            snoop2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] fresh1;
    logic [XLEN-1:0] fresh2;

    // The register file samples the select on the accept edge.
    assign rf_rsel1 = in_instr[19:15];
    assign rf_rsel2 = in_instr[24:20];

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    assign out_valid = (state != EMPTY);
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

    assign in_ready = rst && !flush && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    // A write landing on the accept edge is invisible to the read port.
    assign snoop1 = FWD_EN && wb_wen && (wb_wsel == rf_rsel1)
                    && (rf_rsel1 != 5'd0);
    assign snoop2 = FWD_EN && wb_wen && (wb_wsel == rf_rsel2)
                    && (rf_rsel2 != 5'd0);

    always_comb begin
        fresh1 = '0;
        fresh2 = '0;
        if (rs1 != 5'd0) begin
            fresh1 = fwd1 ? fwd_data1 : rf_rdata1;
        end
        if (rs2 != 5'd0) begin
            fresh2 = fwd2 ? fwd_data2 : rf_rdata2;
        end
    end

    assign out_rs1_data = (state == HELD) ? hold1 : fresh1;
    assign out_rs2_data = (state == HELD) ? hold2 : fresh2;

    always_comb begin
        state_nx = state;
        hold_en  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = FRESH;
                end
            end
            FRESH: begin
                hold_en = !fire;
                if (fire) begin
                    state_nx = accept ? FRESH : EMPTY;
                end else begin
                    state_nx = HELD;
                end
            end
            HELD: begin
                if (fire) begin
                    state_nx = accept ? FRESH : EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q   <= '0;
            pc_q      <= '0;
            fwd1      <= 1'b0;
            fwd2      <= 1'b0;
            fwd_data1 <= '0;
            fwd_data2 <= '0;
        end else if (accept) begin
            instr_q <= in_instr;
            pc_q    <= in_pc;
            fwd1    <= snoop1;
            fwd2    <= snoop2;
            if (snoop1) begin
                fwd_data1 <= wb_wdata;
            end
            if (snoop2) begin
                fwd_data2 <= wb_wdata;
            end
        end
    end

    // rf_rdata follows the next instruction once FRESH ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold1 <= '0;
            hold2 <= '0;
        end else if (hold_en) begin
            hold1 <= fresh1;
            hold2 <= fresh2;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed plan plus randomized traffic
// against a queue-based model and a register file model.
module tb_operand_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdata;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    logic        in_ready, out_valid;
    logic [4:0]  rf_rsel1, rf_rsel2;
    logic [31:0] out_instr, out_pc, out_rs1_data, out_rs2_data;

    logic        n_in_ready, n_out_valid;
    logic [4:0]  n_rsel1, n_rsel2;
    logic [31:0] n_out_instr, n_out_pc, n_rs1, n_rs2;

    operand_fetch #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
    );

    operand_fetch #(.XLEN(32), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_rsel1(n_rsel1), .rf_rsel2(n_rsel2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdata(wb_wdata),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_instr(n_out_instr), .out_pc(n_out_pc),
        .out_rs1_data(n_rs1), .out_rs2_data(n_rs2)
    );

    // Register file: synchronous read returning pre-write data.
    logic [31:0] regs [32] = '{default: 32'h0};
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_rsel1];
        rf_rdata2 <= regs[rf_rsel2];
        if (wb_wen) regs[wb_wsel] <= wb_wdata;
    end

    // Reference: the stage is a one-deep queue of resolved operands.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] n1;
        logic [31:0] n2;
    } ent_t;
    ent_t mq[$];
    ent_t ent;
    logic m_fire, m_acc;
    logic [4:0] m_a, m_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            m_fire = (mq.size() != 0) && out_ready;
            m_acc = in_valid && !flush && ((mq.size() == 0) || out_ready);
            m_a = in_instr[19:15];
            m_b = in_instr[24:20];
            ent.instr = in_instr;
            ent.pc = in_pc;
            ent.n1 = (m_a == 0) ? 32'h0 : regs[m_a];
            ent.n2 = (m_b == 0) ? 32'h0 : regs[m_b];
            ent.r1 = (m_a != 0 && wb_wen && wb_wsel == m_a) ? wb_wdata : ent.n1;
            ent.r2 = (m_b != 0 && wb_wen && wb_wsel == m_b) ? wb_wdata : ent.n2;
            if (m_fire) void'(mq.pop_front());
            if (flush) mq.delete();
            if (m_acc) mq.push_back(ent);
        end
    end

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] ADD = 32'h006283B3;

    function automatic logic [31:0] mk(input logic [4:0] a,
                                       input logic [4:0] b,
                                       input logic [4:0] d);
        return {7'd0, b, a, 3'd0, d, 7'h33};
    endfunction

    task automatic write_reg(input logic [4:0] sel, input logic [31:0] d);
        wb_wen = 1'b1; wb_wsel = sel; wb_wdata = d;
        @(negedge clk);
        wb_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = ADD;
        in_pc = 32'h40; out_ready = 1'b1; wb_wen = 1'b0;
        wb_wsel = 5'd0; wb_wdata = 32'h0;
        repeat (2) @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        vecs++; if (out_instr !== 32'h0) begin errs++; $display("FAIL rst_instr got %h want 0", out_instr); end
        vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL rst_pc got %h want 0", out_pc); end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_rel_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_instr = ADD; in_pc = 32'h100; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        vecs++; if (out_pc !== 32'h100) begin errs++; $display("FAIL basic_pc got %h want 100", out_pc); end
        vecs++; if (out_instr !== ADD) begin errs++; $display("FAIL basic_instr got %h want %h", out_instr, ADD); end
        vecs++; if (out_rs1_data !== 32'h11) begin errs++; $display("FAIL basic_rs1 got %h want 11", out_rs1_data); end
        vecs++; if (out_rs2_data !== 32'h22) begin errs++; $display("FAIL basic_rs2 got %h want 22", out_rs2_data); end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_forward();
        in_valid = 1'b1; in_instr = ADD; in_pc = 32'h104; out_ready = 1'b1;
        wb_wen = 1'b1; wb_wsel = 5'd5; wb_wdata = 32'hCAFEF00D;
        @(negedge clk);
        in_valid = 1'b0; wb_wen = 1'b0;
        vecs++; if (out_rs1_data !== 32'hCAFEF00D) begin errs++; $display("FAIL fwd_rs1 got %h want cafef00d", out_rs1_data); end
        vecs++; if (out_rs2_data !== 32'h22) begin errs++; $display("FAIL fwd_rs2 got %h want 22", out_rs2_data); end
        vecs++; if (n_rs1 !== 32'h11) begin errs++; $display("FAIL nofwd_rs1 got %h want 11", n_rs1); end
        vecs++; if (n_rs2 !== 32'h22) begin errs++; $display("FAIL nofwd_rs2 got %h want 22", n_rs2); end
        @(negedge clk);
        write_reg(5'd5, 32'h11);
    endtask

    task automatic test_backpressure();
        logic [31:0] nxt;
        nxt = mk(5'd1, 5'd2, 5'd3);
        in_valid = 1'b1; in_instr = ADD; in_pc = 32'h200; out_ready = 1'b0;
        @(negedge clk);
        in_instr = nxt; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
            vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got %0b want 1", i, out_valid); end
            vecs++; if (out_instr !== ADD) begin errs++; $display("FAIL bp_instr[%0d] got %h want %h", i, out_instr, ADD); end
            vecs++; if (out_pc !== 32'h200) begin errs++; $display("FAIL bp_pc[%0d] got %h want 200", i, out_pc); end
            vecs++; if (out_rs1_data !== 32'h11) begin errs++; $display("FAIL bp_rs1[%0d] got %h want 11", i, out_rs1_data); end
            vecs++; if (out_rs2_data !== 32'h22) begin errs++; $display("FAIL bp_rs2[%0d] got %h want 22", i, out_rs2_data); end
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vecs++; if (out_instr !== nxt) begin errs++; $display("FAIL bp_next_instr got %h want %h", out_instr, nxt); end
        vecs++; if (out_pc !== 32'h204) begin errs++; $display("FAIL bp_next_pc got %h want 204", out_pc); end
        vecs++; if (out_rs1_data !== 32'hA1) begin errs++; $display("FAIL bp_next_rs1 got %h want a1", out_rs1_data); end
        vecs++; if (out_rs2_data !== 32'hB2) begin errs++; $display("FAIL bp_next_rs2 got %h want b2", out_rs2_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  sa [4];
        logic [4:0]  sb [4];
        logic [31:0] ea [4];
        logic [31:0] eb [4];
        sa = '{5'd1, 5'd5, 5'd2, 5'd6};
        sb = '{5'd2, 5'd6, 5'd5, 5'd1};
        ea = '{32'hA1, 32'h11, 32'hB2, 32'h22};
        eb = '{32'hB2, 32'h22, 32'h11, 32'hA1};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d] got %0b want 1", k - 1, out_valid); end
                vecs++; if (out_pc !== 32'h300 + 32'(4 * (k - 1))) begin errs++; $display("FAIL b2b_pc[%0d] got %h", k - 1, out_pc); end
                vecs++; if (out_rs1_data !== ea[k-1]) begin errs++; $display("FAIL b2b_rs1[%0d] got %h want %h", k - 1, out_rs1_data, ea[k-1]); end
                vecs++; if (out_rs2_data !== eb[k-1]) begin errs++; $display("FAIL b2b_rs2[%0d] got %h want %h", k - 1, out_rs2_data, eb[k-1]); end
            end
            if (k < 4) begin
                in_instr = mk(sa[k], sb[k], 5'd7);
                in_pc = 32'h300 + 32'(4 * k);
                #1;
                vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", k, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_x0();
        in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 5'd9); in_pc = 32'h400;
        out_ready = 1'b1;
        wb_wen = 1'b1; wb_wsel = 5'd0; wb_wdata = 32'hDEADBEEF;
        @(negedge clk);
        wb_wen = 1'b0;
        in_instr = mk(5'd0, 5'd5, 5'd9); in_pc = 32'h404;
        vecs++; if (out_rs1_data !== 32'h0) begin errs++; $display("FAIL x0_rs1 got %h want 0", out_rs1_data); end
        vecs++; if (out_rs2_data !== 32'h0) begin errs++; $display("FAIL x0_rs2 got %h want 0", out_rs2_data); end
        vecs++; if (n_rs1 !== 32'h0) begin errs++; $display("FAIL x0_nf_rs1 got %h want 0", n_rs1); end
        @(negedge clk);
        in_valid = 1'b0;
        vecs++; if (out_rs1_data !== 32'h0) begin errs++; $display("FAIL x0_rf_rs1 got %h want 0", out_rs1_data); end
        vecs++; if (out_rs2_data !== 32'h11) begin errs++; $display("FAIL x0_rf_rs2 got %h want 11", out_rs2_data); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = ADD; in_pc = 32'h500; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL fl_held got %0b want 1", out_valid); end
        flush = 1'b1;
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fl_in_ready got %0b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_valid got %0b want 0", out_valid); end
        vecs++; if (n_out_valid !== 1'b0) begin errs++; $display("FAIL fl_nf_valid got %0b want 0", n_out_valid); end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_after got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = ADD; in_pc = 32'h600; out_ready = 1'b1;
        @(negedge clk);
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rm_fresh got %0b want 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rm_async_valid got %0b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rm_in_ready got %0b want 0", in_ready); end
        @(negedge clk);
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rm_in_ready2 got %0b want 0", in_ready); end
        vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL rm_pc got %h want 0", out_pc); end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rm_no_pulse got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int c = 0; c < 400; c++) begin
            vecs++; if (out_valid !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, out_valid, mq.size() != 0); end
            vecs++; if (n_out_valid !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_nf_valid[%0d] got %0b", c, n_out_valid); end
            if (mq.size() != 0) begin
                vecs++; if (out_instr !== mq[0].instr) begin errs++; $display("FAIL rnd_instr[%0d] got %h want %h", c, out_instr, mq[0].instr); end
                vecs++; if (out_pc !== mq[0].pc) begin errs++; $display("FAIL rnd_pc[%0d] got %h want %h", c, out_pc, mq[0].pc); end
                vecs++; if (out_rs1_data !== mq[0].r1) begin errs++; $display("FAIL rnd_rs1[%0d] got %h want %h", c, out_rs1_data, mq[0].r1); end
                vecs++; if (out_rs2_data !== mq[0].r2) begin errs++; $display("FAIL rnd_rs2[%0d] got %h want %h", c, out_rs2_data, mq[0].r2); end
                vecs++; if (n_rs1 !== mq[0].n1) begin errs++; $display("FAIL rnd_nf_rs1[%0d] got %h want %h", c, n_rs1, mq[0].n1); end
                vecs++; if (n_rs2 !== mq[0].n2) begin errs++; $display("FAIL rnd_nf_rs2[%0d] got %h want %h", c, n_rs2, mq[0].n2); end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            in_instr = $urandom;
            in_instr[19:15] = 5'($urandom_range(0, 7));
            in_instr[24:20] = 5'($urandom_range(0, 7));
            in_pc = $urandom & 32'hFFFF_FFFC;
            wb_wen = ($urandom_range(0, 1) != 0);
            wb_wsel = ($urandom_range(0, 1) != 0) ? in_instr[19:15] : 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            #1;
            exp_rdy = !flush && ((mq.size() == 0) || out_ready);
            vecs++; if (in_ready !== exp_rdy) begin errs++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", c, in_ready, exp_rdy); end
            vecs++; if (rf_rsel1 !== in_instr[19:15]) begin errs++; $display("FAIL rnd_rsel1[%0d] got %0d want %0d", c, rf_rsel1, in_instr[19:15]); end
            vecs++; if (rf_rsel2 !== in_instr[24:20]) begin errs++; $display("FAIL rnd_rsel2[%0d] got %0d want %0d", c, rf_rsel2, in_instr[24:20]); end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; wb_wen = 1'b0;
    endtask

    initial begin
        test_reset();
        write_reg(5'd1, 32'hA1);
        write_reg(5'd2, 32'hB2);
        write_reg(5'd5, 32'h11);
        write_reg(5'd6, 32'h22);
        test_basic();
        test_forward();
        test_backpressure();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
